// File: rtl/alu_sequencer_if.sv
// Bundle of operand, ALU and result handshake signals around the ALU sequencer.
// The sequencer uses the slave modport; the environment driving it uses master.
interface alu_sequencer_if #(
  parameter int WIDTH = 4
);
  logic               i_valid;
  logic               o_ready;
  logic [WIDTH-1:0]   i_data;
  logic [2:0]         i_op;
  logic [WIDTH-1:0]   o_alu_a;
  logic [WIDTH-1:0]   o_alu_b;
  logic [2:0]         o_alu_s;
  logic [2*WIDTH-1:0] i_alu_res;
  logic               o_valid;
  logic               i_ready;
  logic [2*WIDTH-1:0] o_result;
  logic               o_err;
  logic [7:0]         o_op_cnt;

  modport slave (
    input  i_valid, i_data, i_op, i_alu_res, i_ready,
    output o_ready, o_alu_a, o_alu_b, o_alu_s, o_valid, o_result, o_err, o_op_cnt
  );

  modport master (
    output i_valid, i_data, i_op, i_alu_res, i_ready,
    input  o_ready, o_alu_a, o_alu_b, o_alu_s, o_valid, o_result, o_err, o_op_cnt
  );
endinterface

// File: rtl/alu_sequencer.sv
// Two-beat operand collector that drives an external combinational ALU and
// returns its registered result over a valid/ready handshake.
//
// state  | meaning
// IDLE   | waiting for operand A beat
// WAIT_B | A held, waiting for operand B beat and op select
// EXEC   | one cycle for the external ALU to settle
// OUT    | result presented until downstream accepts it
module alu_sequencer #(
  parameter int WIDTH = 4
) (
  input logic           i_clk,
  input logic           i_rst_n,
  input logic           i_clear,
  alu_sequencer_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT_B = 2'd1;
  localparam logic [1:0] EXEC   = 2'd2;
  localparam logic [1:0] OUT    = 2'd3;

  logic [1:0]         state;
  logic [WIDTH-1:0]   aluA;
  logic [WIDTH-1:0]   aluB;
  logic [2:0]         aluS;
  logic [2*WIDTH-1:0] result;
  logic               resValid;
  logic               resErr;
  logic [7:0]         opCnt;
  logic               inReady;
  logic               inHs;
  logic               outHs;

  // Ready depends on state alone so upstream never sees a valid->ready loop.
  assign inReady = (state == IDLE) || (state == WAIT_B);
  assign inHs    = bus.i_valid && inReady;
  assign outHs   = resValid && bus.i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      aluA     <= '0;
      aluB     <= '0;
      aluS     <= '0;
      result   <= '0;
      resValid <= 1'b0;
      resErr   <= 1'b0;
      opCnt    <= '0;
    end else if (i_clear) begin
      // Abort drops any beat or result in flight but keeps the datapath values.
      state    <= IDLE;
      resValid <= 1'b0;
      resErr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (inHs) begin
            aluA  <= bus.i_data;
            state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (inHs) begin
            aluB  <= bus.i_data;
            aluS  <= bus.i_op;
            state <= EXEC;
          end
        end
        EXEC: begin
          result   <= bus.i_alu_res;
          resErr   <= (aluS >= 3'b110);
          resValid <= 1'b1;
          state    <= OUT;
        end
        OUT: begin
          if (outHs) begin
            resValid <= 1'b0;
            opCnt    <= opCnt + 8'd1;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          resValid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready  = inReady;
  assign bus.o_alu_a  = aluA;
  assign bus.o_alu_b  = aluB;
  assign bus.o_alu_s  = aluS;
  assign bus.o_result = result;
  assign bus.o_valid  = resValid;
  assign bus.o_err    = resErr;
  assign bus.o_op_cnt = opCnt;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized scoreboard bench for alu_sequencer; the ALU itself is modelled here
// and expected results are derived from the stimulus operands, not DUT state.
module tb_alu_sequencer;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  logic clear;

  alu_sequencer_if #(.WIDTH(W)) bus ();

  alu_sequencer #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clear (clear),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0] res;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   modelCnt = 0;
  bit   seen = 0;
  bit   cntPending = 0;
  bit   readyMode = 0;
  bit   readyVal = 1;
  logic [3:0] lastA, lastB;
  logic [2:0] lastOp;

  function automatic logic [7:0] aluModel(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] op);
    logic [7:0] ax, bx;
    ax = {4'h0, a};
    bx = {4'h0, b};
    case (op)
      3'd0:    return ax & bx;
      3'd1:    return ax + bx;
      3'd2:    return ax - bx;
      3'd3:    return ax << 1;
      3'd4:    return ax * bx;
      3'd5:    return ax ^ bx;
      default: return 8'h00;
    endcase
  endfunction

  assign bus.i_alu_res = aluModel(bus.o_alu_a, bus.o_alu_b, bus.o_alu_s);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready changes just after each rising edge so it is stable at sampling.
  initial forever begin
    @(posedge clk);
    #1;
    bus.i_ready = readyMode ? 1'($urandom_range(0, 1)) : readyVal;
  end

  // Monitor: compares every presented result against the scoreboard head.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (cntPending) begin
        chk("op_cnt", {24'h0, bus.o_op_cnt}, modelCnt % 256);
        cntPending = 0;
      end
      if (bus.o_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", {31'h0, bus.o_valid}, 0);
        end else begin
          if (!seen) chk("latency", cyc, sb[0].cyc);
          seen = 1;
          chk("result", {24'h0, bus.o_result}, {24'h0, sb[0].res});
          chk("err", {31'h0, bus.o_err}, {31'h0, sb[0].err});
          chk("ready_in_out", {31'h0, bus.o_ready}, 0);
          if (bus.i_ready) begin
            void'(sb.pop_front());
            seen = 0;
            modelCnt++;
            cntPending = 1;
          end
        end
      end
    end
  end

  task automatic waitReady();
    for (int i = 0; i < 60 && !bus.o_ready; i++) @(negedge clk);
    if (!bus.o_ready) chk("ready_timeout", {31'h0, bus.o_ready}, 1);
  endtask

  task automatic sendA(input logic [3:0] a);
    @(negedge clk);
    waitReady();
    bus.i_valid = 1;
    bus.i_data  = a;
    bus.i_op    = 3'($urandom);
    @(posedge clk);
    #1 bus.i_valid = 0;
    lastA = a;
  endtask

  task automatic sendB(input logic [3:0] b, input logic [2:0] op);
    exp_t e;
    @(negedge clk);
    waitReady();
    bus.i_valid = 1;
    bus.i_data  = b;
    bus.i_op    = op;
    @(posedge clk);
    #1 bus.i_valid = 0;
    lastB  = b;
    lastOp = op;
    e.res = aluModel(lastA, b, op);
    e.err = (op >= 3'b110);
    e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic waitValid();
    for (int i = 0; i < 20 && !bus.o_valid; i++) @(negedge clk);
    chk("valid_rise", {31'h0, bus.o_valid}, 1);
  endtask

  initial begin
    rst_n = 0;
    clear = 0;
    bus.i_valid = 0;
    bus.i_data  = 0;
    bus.i_op    = 0;
    bus.i_ready = 1;
    #2;
    chk("rst_valid", {31'h0, bus.o_valid}, 0);
    chk("rst_result", {24'h0, bus.o_result}, 0);
    chk("rst_alu_a", {28'h0, bus.o_alu_a}, 0);
    chk("rst_cnt", {24'h0, bus.o_op_cnt}, 0);
    chk("rst_ready", {31'h0, bus.o_ready}, 1);

    // A beat presented while still in reset is taken on the first edge after release.
    @(negedge clk);
    bus.i_valid = 1;
    bus.i_data  = 4'd9;
    #2 rst_n = 1;
    @(posedge clk);
    #1 bus.i_valid = 0;
    lastA = 4'd9;
    chk("first_edge_a", {28'h0, bus.o_alu_a}, 9);
    sendB(4'd5, 3'b001);
    drain();
    chk("cnt_first", {24'h0, bus.o_op_cnt}, 1);
    chk("alu_s_hold", {29'h0, bus.o_alu_s}, {29'h0, lastOp});

    sendA(4'd3); sendB(4'd5, 3'b010);
    sendA(4'hF); sendB(4'($urandom), 3'b011);
    drain();

    // Result held for five cycles while ready is low; stray beats must be ignored.
    readyVal = 0;
    sendA(4'($urandom)); sendB(4'($urandom), 3'b111);
    waitValid();
    bus.i_valid = 1;
    bus.i_data  = ~lastA;
    repeat (5) @(negedge clk);
    bus.i_valid = 0;
    chk("ignore_a", {28'h0, bus.o_alu_a}, {28'h0, lastA});
    chk("ignore_b", {28'h0, bus.o_alu_b}, {28'h0, lastB});
    readyVal = 1;
    drain();

    // Clear alongside the B beat: beat dropped, nothing produced.
    sendA(4'd7);
    @(negedge clk);
    bus.i_valid = 1;
    bus.i_data  = 4'd2;
    bus.i_op    = 3'b001;
    clear = 1;
    @(posedge clk);
    #1 bus.i_valid = 0;
    clear = 0;
    chk("clear_ready", {31'h0, bus.o_ready}, 1);
    chk("clear_alu_a", {28'h0, bus.o_alu_a}, 7);
    chk("clear_alu_b", {28'h0, bus.o_alu_b}, {28'h0, lastB});
    chk("clear_cnt", {24'h0, bus.o_op_cnt}, modelCnt % 256);
    repeat (4) @(negedge clk);
    sendA(4'($urandom)); sendB(4'($urandom), 3'($urandom));
    drain();

    // Asynchronous reset while a result waits in OUT.
    readyVal = 0;
    sendA(4'($urandom)); sendB(4'($urandom), 3'b001);
    waitValid();
    #1 rst_n = 0;
    sb.delete();
    seen = 0;
    cntPending = 0;
    modelCnt = 0;
    #1;
    chk("arst_valid", {31'h0, bus.o_valid}, 0);
    chk("arst_result", {24'h0, bus.o_result}, 0);
    chk("arst_cnt", {24'h0, bus.o_op_cnt}, 0);
    chk("arst_err", {31'h0, bus.o_err}, 0);
    chk("arst_ready", {31'h0, bus.o_ready}, 1);
    bus.i_valid = 1;
    bus.i_data  = 4'd12;
    #1 rst_n = 1;
    readyVal = 1;
    @(posedge clk);
    #1 bus.i_valid = 0;
    lastA = 4'd12;
    chk("post_rst_a", {28'h0, bus.o_alu_a}, 12);
    sendB(4'd3, 3'b100);
    drain();

    // Counter wrap under random traffic and random downstream stalls.
    readyMode = 1;
    for (int i = 0; i < 255; i++) begin
      sendA(4'($urandom)); sendB(4'($urandom), 3'($urandom));
    end
    drain();
    chk("wrap_zero", {24'h0, bus.o_op_cnt}, 0);
    for (int i = 0; i < 5; i++) begin
      sendA(4'($urandom)); sendB(4'($urandom), 3'($urandom));
    end
    drain();
    chk("wrap_five", {24'h0, bus.o_op_cnt}, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end
endmodule
